// File: rtl/adc_spi_pkg.sv
// Shared constants, FSM state type and config-to-channel mapping for the
// ADC-style SPI responder.
package adc_spi_pkg;

  localparam int CFG_W  = 6;
  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } state_t;

  // Config word layout is {S/D, O/S, S1, S0, UNI, SLP}; the channel number is
  // built as {S1, S0, O/S}.
  function automatic logic [CH_W-1:0] cfg_to_ch(input logic [CFG_W-1:0] cfg);
    return {cfg[3], cfg[2], cfg[4]};
  endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// SPI pin bundle between an SPI master and the responder.
interface adc_spi_responder_if;

  logic spi_sclk;
  logic spi_ss_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_sclk,
    output spi_ss_n,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );

  modport slave (
    input  spi_sclk,
    input  spi_ss_n,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );

endinterface

// File: rtl/adc_spi_responder_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus single-cycle rise and
// fall pulses on the synchronized level.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_r;
  logic              prev_r;
  logic              level_s;

  assign level_s = chain_r[STAGES-1];

  // Synchronizer chain and one-cycle-delayed copy of its output for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= {STAGES{1'b0}};
      prev_r  <= 1'b0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], din};
      prev_r  <= level_s;
    end
  end

  assign rise = level_s & ~prev_r;
  assign fall = ~level_s & prev_r;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating a multi-channel ADC: receives a 6-bit config word
// on MOSI while returning a DATA_W-bit channel result on MISO. The config of
// one frame selects the data of the next frame. All SPI pins are
// oversampled on clk_50.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 12
) (
  input  logic               clk_50,
  input  logic               reset_n,
  adc_spi_responder_if.slave spi,
  input  logic               wr_en,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               cfg_valid,
  output logic [CFG_W-1:0]   cfg_word,
  output logic               frame_err
);

  logic              sclk_rise_s;
  logic              sclk_fall_s;
  logic              ss_rise_s;
  logic              ss_fall_s;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic              mosi_s;

  state_t            state_r;
  logic [3:0]        bit_cnt_r;
  logic [CFG_W-1:0]  rx_cfg_r;
  logic [DATA_W-1:0] tx_r;
  logic              miso_r;
  logic              oe_r;
  logic [CFG_W-1:0]  cfg_word_r;
  logic [CH_W-1:0]   pend_ch_r;
  logic              pend_slp_r;
  logic              cfg_valid_r;
  logic              frame_err_r;
  logic [DATA_W-1:0] chan_r [NUM_CH];
  logic [DATA_W-1:0] load_s;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk   (clk_50),
    .rst_n (reset_n),
    .din   (spi.spi_sclk),
    .rise  (sclk_rise_s),
    .fall  (sclk_fall_s)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk   (clk_50),
    .rst_n (reset_n),
    .din   (spi.spi_ss_n),
    .rise  (ss_rise_s),
    .fall  (ss_fall_s)
  );

  // MOSI only needs the level, sampled on synced sclk rises.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi.spi_mosi};
    end
  end

  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

  // Channel result registers written from the host side.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        chan_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (wr_en) begin
        chan_r[wr_ch] <= wr_data;
      end
    end
  end

  // Word captured into the tx shifter at frame start; sleep mode returns zeros.
  always_comb begin
    load_s = {DATA_W{1'b0}};
    if (pend_slp_r) begin
      load_s = {DATA_W{1'b0}};
    end else begin
      load_s = chan_r[pend_ch_r];
    end
  end

  // Frame FSM: shifts config in and result out, commits config at frame end.
  // An ss_n rise is handled before returning to IDLE, so a back-to-back
  // frame start one cycle later already sees the updated pending channel.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 4'd0;
      rx_cfg_r    <= {CFG_W{1'b0}};
      tx_r        <= {DATA_W{1'b0}};
      miso_r      <= 1'b0;
      oe_r        <= 1'b0;
      cfg_word_r  <= {CFG_W{1'b0}};
      pend_ch_r   <= {CH_W{1'b0}};
      pend_slp_r  <= 1'b0;
      cfg_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      cfg_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (ss_fall_s) begin
            state_r   <= SHIFT;
            tx_r      <= load_s;
            miso_r    <= load_s[DATA_W-1];
            oe_r      <= 1'b1;
            bit_cnt_r <= 4'd0;
            rx_cfg_r  <= {CFG_W{1'b0}};
          end else begin
            miso_r <= 1'b0;
            oe_r   <= 1'b0;
          end
        end
        SHIFT, TAIL: begin
          if (ss_rise_s) begin
            state_r <= IDLE;
            miso_r  <= 1'b0;
            oe_r    <= 1'b0;
            if (bit_cnt_r >= 4'd6) begin
              cfg_word_r  <= rx_cfg_r;
              pend_ch_r   <= cfg_to_ch(rx_cfg_r);
              pend_slp_r  <= rx_cfg_r[0];
              cfg_valid_r <= 1'b1;
            end
            if (bit_cnt_r < 4'd12) begin
              frame_err_r <= 1'b1;
            end
          end else if (state_r == SHIFT) begin
            if (sclk_rise_s) begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r < 4'd6) begin
                rx_cfg_r <= {rx_cfg_r[CFG_W-2:0], mosi_s};
              end
              if (bit_cnt_r == 4'd11) begin
                // Twelfth bit consumed: MISO idles low until the frame closes.
                state_r <= TAIL;
                miso_r  <= 1'b0;
              end
            end else if (sclk_fall_s && (bit_cnt_r >= 4'd1) && (bit_cnt_r <= 4'd11)) begin
              // Rotate rather than shift so every stored bit stays observable.
              tx_r   <= {tx_r[DATA_W-2:0], tx_r[DATA_W-1]};
              miso_r <= tx_r[DATA_W-2];
            end
          end else begin
            miso_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          miso_r  <= 1'b0;
          oe_r    <= 1'b0;
        end
      endcase
    end
  end

  assign spi.spi_miso    = miso_r;
  assign spi.spi_miso_oe = oe_r;
  assign cfg_valid       = cfg_valid_r;
  assign cfg_word        = cfg_word_r;
  assign frame_err       = frame_err_r;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed self-checking bench for adc_spi_responder (SYNC_STAGES=2, DATA_W=12).
module tb_adc_spi_responder;

  logic        clk_50;
  logic        reset_n;
  logic        wr_en;
  logic [2:0]  wr_ch;
  logic [11:0] wr_data;
  logic        cfg_valid;
  logic [5:0]  cfg_word;
  logic        frame_err;

  int n_vec;
  int n_err;
  int cv_cnt;
  int fe_cnt;

  adc_spi_responder_if spi_bus ();

  adc_spi_responder #(.SYNC_STAGES(2), .DATA_W(12)) dut (
    .clk_50    (clk_50),
    .reset_n   (reset_n),
    .spi       (spi_bus),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_data   (wr_data),
    .cfg_valid (cfg_valid),
    .cfg_word  (cfg_word),
    .frame_err (frame_err)
  );

  initial begin
    clk_50 = 1'b0;
    forever #10 clk_50 = ~clk_50;
  end

  // Count high cycles of the two pulse outputs.
  always @(negedge clk_50) begin
    if (cfg_valid === 1'b1) cv_cnt <= cv_cnt + 1;
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
  end

  task automatic write_ch(input logic [2:0] ch, input logic [11:0] data);
    wr_ch   = ch;
    wr_data = data;
    wr_en   = 1'b1;
    @(negedge clk_50);
    wr_en = 1'b0;
    @(negedge clk_50);
  endtask

  // SPI master, mode 0, sclk half period = 5 clk_50 cycles. Called just after a negedge.
  task automatic run_frame(input logic [5:0] cfg, input int pulses, input int gap,
                           input int wr_at, input logic [2:0] wch, input logic [11:0] wdat,
                           input int abort_at, output logic [11:0] rx);
    rx = 12'h000;
    spi_bus.spi_ss_n = 1'b0;
    repeat (5) @(negedge clk_50);
    for (int i = 0; i < pulses; i++) begin
      spi_bus.spi_mosi = (i < 6) ? cfg[5-i] : 1'b0;
      if (i == wr_at) begin
        wr_ch   = wch;
        wr_data = wdat;
        wr_en   = 1'b1;
      end
      @(negedge clk_50);
      wr_en = 1'b0;
      repeat (4) @(negedge clk_50);
      if (i == abort_at) return;
      rx = {rx[10:0], spi_bus.spi_miso};
      spi_bus.spi_sclk = 1'b1;
      repeat (5) @(negedge clk_50);
      spi_bus.spi_sclk = 1'b0;
    end
    repeat (5) @(negedge clk_50);
    spi_bus.spi_ss_n = 1'b1;
    repeat (gap) @(negedge clk_50);
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    #5 reset_n = 1'b0;
    repeat (3) @(negedge clk_50);
    n_vec++; if (spi_bus.spi_miso !== 1'b0) begin n_err++; $display("FAIL reset_miso: got %b want 0", spi_bus.spi_miso); end
    n_vec++; if (spi_bus.spi_miso_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe: got %b want 0", spi_bus.spi_miso_oe); end
    n_vec++; if (cfg_valid !== 1'b0) begin n_err++; $display("FAIL reset_cfg_valid: got %b want 0", cfg_valid); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_vec++; if (cfg_word !== 6'h00) begin n_err++; $display("FAIL reset_cfg_word: got %h want 00", cfg_word); end
    reset_n = 1'b1;
    repeat (8) @(negedge clk_50);
    n_vec++; if (fe_cnt !== 0 || cv_cnt !== 0) begin n_err++; $display("FAIL reset_release_pulses: got cv=%0d fe=%0d want 0 0", cv_cnt, fe_cnt); end
  endtask

  task automatic test_reset_data;
    logic [11:0] rx;
    int cv0, fe0;
    cv0 = cv_cnt; fe0 = fe_cnt;
    // ch0 written mid-frame: this frame must still return reset data
    run_frame(6'b100010, 12, 8, 2, 3'd0, 12'hABC, -1, rx);
    n_vec++; if (rx !== 12'h000) begin n_err++; $display("FAIL first_frame_miso: got %h want 000", rx); end
    n_vec++; if (cfg_word !== 6'h22) begin n_err++; $display("FAIL first_cfg_word: got %h want 22", cfg_word); end
    n_vec++; if (cv_cnt - cv0 !== 1) begin n_err++; $display("FAIL first_cfg_valid_cycles: got %0d want 1", cv_cnt - cv0); end
    n_vec++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL first_frame_err: got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_pipeline;
    logic [11:0] rx;
    run_frame(6'b110010, 12, 8, -1, 3'd0, 12'h000, -1, rx);
    n_vec++; if (rx !== 12'hABC) begin n_err++; $display("FAIL pipe_frame1_miso: got %h want ABC", rx); end
    n_vec++; if (cfg_word !== 6'h32) begin n_err++; $display("FAIL pipe_cfg_word: got %h want 32", cfg_word); end
    write_ch(3'd1, 12'h5A5);
    run_frame(6'b100010, 12, 8, -1, 3'd0, 12'h000, -1, rx);
    n_vec++; if (rx !== 12'h5A5) begin n_err++; $display("FAIL pipe_frame2_miso: got %h want 5A5", rx); end
  endtask

  task automatic test_sleep;
    logic [11:0] rx;
    run_frame(6'b100011, 12, 8, -1, 3'd0, 12'h000, -1, rx);
    n_vec++; if (rx !== 12'hABC) begin n_err++; $display("FAIL sleep_setup_miso: got %h want ABC", rx); end
    run_frame(6'b100010, 12, 8, -1, 3'd0, 12'h000, -1, rx);
    n_vec++; if (rx !== 12'h000) begin n_err++; $display("FAIL sleep_miso: got %h want 000", rx); end
  endtask

  task automatic test_short_frame;
    logic [11:0] rx;
    int cv0, fe0;
    cv0 = cv_cnt; fe0 = fe_cnt;
    run_frame(6'b110010, 4, 8, -1, 3'd0, 12'h000, -1, rx);
    n_vec++; if (rx !== 12'h00A) begin n_err++; $display("FAIL short4_miso: got %h want 00A", rx); end
    n_vec++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL short4_frame_err: got %0d want 1", fe_cnt - fe0); end
    n_vec++; if (cv_cnt - cv0 !== 0) begin n_err++; $display("FAIL short4_cfg_valid: got %0d want 0", cv_cnt - cv0); end
    n_vec++; if (cfg_word !== 6'h22) begin n_err++; $display("FAIL short4_cfg_word: got %h want 22", cfg_word); end
    cv0 = cv_cnt; fe0 = fe_cnt;
    run_frame(6'b110010, 8, 8, -1, 3'd0, 12'h000, -1, rx);
    n_vec++; if (rx !== 12'h0AB) begin n_err++; $display("FAIL short8_miso: got %h want 0AB", rx); end
    n_vec++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL short8_frame_err: got %0d want 1", fe_cnt - fe0); end
    n_vec++; if (cv_cnt - cv0 !== 1) begin n_err++; $display("FAIL short8_cfg_valid: got %0d want 1", cv_cnt - cv0); end
    n_vec++; if (cfg_word !== 6'h32) begin n_err++; $display("FAIL short8_cfg_word: got %h want 32", cfg_word); end
  endtask

  task automatic test_write_during_frame;
    logic [11:0] rx;
    write_ch(3'd1, 12'h123);
    run_frame(6'b110010, 12, 8, 5, 3'd1, 12'hFFF, -1, rx);
    n_vec++; if (rx !== 12'h123) begin n_err++; $display("FAIL wr_mid_frameN: got %h want 123", rx); end
    run_frame(6'b110010, 12, 8, -1, 3'd0, 12'h000, -1, rx);
    n_vec++; if (rx !== 12'hFFF) begin n_err++; $display("FAIL wr_mid_frameN1: got %h want FFF", rx); end
  endtask

  task automatic test_back_to_back;
    logic [11:0] rx;
    int cv0;
    write_ch(3'd2, 12'h3C6);
    cv0 = cv_cnt;
    run_frame(6'b100110, 12, 1, -1, 3'd0, 12'h000, -1, rx);
    n_vec++; if (rx !== 12'hFFF) begin n_err++; $display("FAIL b2b_first_miso: got %h want FFF", rx); end
    run_frame(6'b100010, 12, 8, -1, 3'd0, 12'h000, -1, rx);
    n_vec++; if (rx !== 12'h3C6) begin n_err++; $display("FAIL b2b_second_miso: got %h want 3C6", rx); end
    n_vec++; if (cv_cnt - cv0 !== 2) begin n_err++; $display("FAIL b2b_cfg_valid: got %0d want 2", cv_cnt - cv0); end
  endtask

  task automatic test_reset_mid_frame;
    logic [11:0] rx;
    int cv0, fe0;
    write_ch(3'd0, 12'hFFF);
    run_frame(6'b100010, 12, 8, -1, 3'd0, 12'h000, 7, rx);
    n_vec++; if (spi_bus.spi_miso !== 1'b1 || spi_bus.spi_miso_oe !== 1'b1) begin n_err++; $display("FAIL midrst_before: got miso=%b oe=%b want 1 1", spi_bus.spi_miso, spi_bus.spi_miso_oe); end
    cv0 = cv_cnt; fe0 = fe_cnt;
    reset_n = 1'b0;
    #1;
    n_vec++; if (spi_bus.spi_miso !== 1'b0 || spi_bus.spi_miso_oe !== 1'b0) begin n_err++; $display("FAIL midrst_immediate: got miso=%b oe=%b want 0 0", spi_bus.spi_miso, spi_bus.spi_miso_oe); end
    @(negedge clk_50);
    spi_bus.spi_ss_n = 1'b1;
    repeat (3) @(negedge clk_50);
    reset_n = 1'b1;
    repeat (8) @(negedge clk_50);
    n_vec++; if (cv_cnt - cv0 !== 0 || fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL midrst_pulses: got cv=%0d fe=%0d want 0 0", cv_cnt - cv0, fe_cnt - fe0); end
    n_vec++; if (cfg_word !== 6'h00) begin n_err++; $display("FAIL midrst_cfg_word: got %h want 00", cfg_word); end
    cv0 = cv_cnt;
    run_frame(6'b100010, 12, 8, -1, 3'd0, 12'h000, -1, rx);
    n_vec++; if (rx !== 12'h000) begin n_err++; $display("FAIL midrst_after_miso: got %h want 000", rx); end
    n_vec++; if (cv_cnt - cv0 !== 1) begin n_err++; $display("FAIL midrst_after_cfg_valid: got %0d want 1", cv_cnt - cv0); end
  endtask

  task automatic test_latency;
    logic [5:0] cfg;
    cfg = 6'b100010;
    write_ch(3'd0, 12'h800);
    spi_bus.spi_ss_n = 1'b0;
    repeat (2) @(negedge clk_50);
    n_vec++; if (spi_bus.spi_miso !== 1'b0) begin n_err++; $display("FAIL lat_miso_early: got %b want 0", spi_bus.spi_miso); end
    @(negedge clk_50);
    n_vec++; if (spi_bus.spi_miso !== 1'b1) begin n_err++; $display("FAIL lat_miso_on_time: got %b want 1", spi_bus.spi_miso); end
    for (int i = 0; i < 6; i++) begin
      spi_bus.spi_mosi = cfg[5-i];
      repeat (5) @(negedge clk_50);
      spi_bus.spi_sclk = 1'b1;
      repeat (5) @(negedge clk_50);
      spi_bus.spi_sclk = 1'b0;
    end
    repeat (5) @(negedge clk_50);
    spi_bus.spi_ss_n = 1'b1;
    repeat (2) @(negedge clk_50);
    n_vec++; if (cfg_valid !== 1'b0) begin n_err++; $display("FAIL lat_cfg_valid_early: got %b want 0", cfg_valid); end
    @(negedge clk_50);
    n_vec++; if (cfg_valid !== 1'b1) begin n_err++; $display("FAIL lat_cfg_valid_on_time: got %b want 1", cfg_valid); end
    @(negedge clk_50);
    n_vec++; if (cfg_valid !== 1'b0) begin n_err++; $display("FAIL lat_cfg_valid_width: got %b want 0", cfg_valid); end
    repeat (5) @(negedge clk_50);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cv_cnt = 0;
    fe_cnt = 0;
    wr_en = 1'b0;
    wr_ch = 3'd0;
    wr_data = 12'h000;
    spi_bus.spi_sclk = 1'b0;
    spi_bus.spi_ss_n = 1'b1;
    spi_bus.spi_mosi = 1'b0;
    test_reset;
    test_reset_data;
    test_pipeline;
    test_sleep;
    test_short_frame;
    test_write_during_frame;
    test_back_to_back;
    test_reset_mid_frame;
    test_latency;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
